// File: rtl/sp_ram_param_pkg.sv
// Shared types and helpers for the parameterised single-port RAM.
// Holds the controller state encoding and the byte-lane count helper.
package sp_ram_param_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sp_ram_core.sv
// Plain storage array: byte-enable write and registered read, no reset.
// Contents are only ever zeroed by the controller's clear sweep.
module sp_ram_core
  import sp_ram_param_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic                          re,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [lane_count(DATA_W)-1:0] be,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);

  localparam int LANES = lane_count(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write per lane and registered read; rdata holds when not reading.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && be[i]) begin
        mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/sp_ram_param.sv
// Single-port RAM controller: clear sweep after reset or clr, request
// acceptance, and a one- or two-stage read response pipeline.
module sp_ram_param
  import sp_ram_param_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int OUT_REG = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [lane_count(DATA_W)-1:0] req_be,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          init_busy
);

  localparam int LANES = lane_count(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  state_e             state_r, state_s;
  logic [ADDR_W-1:0]  clr_cnt_r;
  logic               accept_s, clr_run_s, rd_v1_r;
  logic               core_we_s, core_re_s;
  logic [ADDR_W-1:0]  core_addr_s;
  logic [LANES-1:0]   core_be_s;
  logic [DATA_W-1:0]  core_wdata_s, core_rdata_s;

  assign req_ready = (state_r == RUN);
  assign init_busy = (state_r == INIT);
  assign clr_run_s = clr && (state_r == RUN);
  assign accept_s  = req_valid && req_ready && !clr;

  // Next-state: the sweep ends after the last address; clr only matters in RUN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: begin
        if (clr_cnt_r == ADDR_W'(DEPTH - 1)) state_s = RUN;
        else                                 state_s = INIT;
      end
      RUN: begin
        if (clr) state_s = INIT;
        else     state_s = RUN;
      end
      default: state_s = INIT;
    endcase
  end

  // Storage port mux: the sweep owns the array while INIT is active.
  always_comb begin
    core_we_s    = 1'b0;
    core_re_s    = 1'b0;
    core_addr_s  = req_addr;
    core_be_s    = req_be;
    core_wdata_s = req_wdata;
    if (state_r == INIT) begin
      core_we_s    = 1'b1;
      core_addr_s  = clr_cnt_r;
      core_be_s    = {LANES{1'b1}};
      core_wdata_s = {DATA_W{1'b0}};
    end else begin
      core_we_s = accept_s && req_we;
      core_re_s = accept_s && !req_we;
    end
  end

  // State, clear counter and first read-valid stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= INIT;
      clr_cnt_r <= {ADDR_W{1'b0}};
      rd_v1_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      rd_v1_r <= core_re_s;
      if (state_r == INIT) begin
        clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
      end else if (clr_run_s) begin
        clr_cnt_r <= {ADDR_W{1'b0}};
      end else begin
        clr_cnt_r <= clr_cnt_r;
      end
    end
  end

  sp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we_s),
    .re    (core_re_s),
    .addr  (core_addr_s),
    .be    (core_be_s),
    .wdata (core_wdata_s),
    .rdata (core_rdata_s)
  );

  generate
    if (OUT_REG == 0) begin : g_lat1
      logic [DATA_W-1:0] hold_r;

      // Remember the last delivered word so rsp_rdata is stable between responses.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_r <= {DATA_W{1'b0}};
        end else if (rd_v1_r) begin
          hold_r <= core_rdata_s;
        end else begin
          hold_r <= hold_r;
        end
      end

      assign rsp_valid = rd_v1_r;
      assign rsp_rdata = rd_v1_r ? core_rdata_s : hold_r;
    end else begin : g_lat2
      logic              rsp_valid_r;
      logic [DATA_W-1:0] rsp_rdata_r;

      // Output stage; a clr in RUN squashes the read still in flight.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
          rsp_valid_r <= rd_v1_r && !clr_run_s;
          if (rd_v1_r && !clr_run_s) begin
            rsp_rdata_r <= core_rdata_s;
          end else begin
            rsp_rdata_r <= rsp_rdata_r;
          end
        end
      end

      assign rsp_valid = rsp_valid_r;
      assign rsp_rdata = rsp_rdata_r;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_param.sv
// Scoreboard bench: a default instance (8-bit, latency 1) and a wide one
// (32-bit, latency 2) share stimulus and one word-level memory model.
module tb_sp_ram_param;

  logic        clk = 1'b0;
  logic        rst_n, clr, req_valid, req_we;
  logic [2:0]  req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rdy0, rv0, busy0, rdy1, rv1, busy1;
  logic [7:0]  rd0;
  logic [31:0] rd1;

  always #5 clk = ~clk;

  sp_ram_param u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(rdy0),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be[0]), .req_wdata(req_wdata[7:0]),
    .rsp_valid(rv0), .rsp_rdata(rd0), .init_busy(busy0)
  );

  sp_ram_param #(.DATA_W(32), .ADDR_W(3), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .init_busy(busy1)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  logic [31:0] model_mem [8];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          init_left = 8;
  bit          exp_busy = 1'b1;
  bit          prev_rd = 1'b0;
  logic [31:0] last0 = 32'd0;
  logic [31:0] last1 = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: control outputs every cycle, responses popped against the scoreboard.
  always @(negedge clk) begin
    check("ready0", {31'd0, rdy0}, {31'd0, !exp_busy});
    check("busy0",  {31'd0, busy0}, {31'd0, exp_busy});
    check("ready1", {31'd0, rdy1}, {31'd0, !exp_busy});
    check("busy1",  {31'd0, busy1}, {31'd0, exp_busy});
    if (rv0) begin
      if (q0.size() == 0) check("rsp0_unexpected", {31'd0, rv0}, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("rsp0_data", {24'd0, rd0}, e0.data);
        check("rsp0_latency", cyc, e0.due);
        last0 = e0.data;
      end
    end else begin
      if (q0.size() > 0 && q0[0].due <= cyc) begin
        void'(q0.pop_front());
        check("rsp0_missing", {31'd0, rv0}, 32'd1);
      end
      check("rsp0_hold", {24'd0, rd0}, last0);
    end
    if (rv1) begin
      if (q1.size() == 0) check("rsp1_unexpected", {31'd0, rv1}, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("rsp1_data", rd1, e1.data);
        check("rsp1_latency", cyc, e1.due);
        last1 = e1.data;
      end
    end else begin
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        void'(q1.pop_front());
        check("rsp1_missing", {31'd0, rv1}, 32'd1);
      end
      check("rsp1_hold", rd1, last1);
    end
  end

  task automatic zero_model();
    for (int i = 0; i < 8; i++) model_mem[i] = 32'd0;
  endtask

  // One cycle of stimulus, called just after a rising edge.
  task automatic step(input bit v, input bit we, input int a, input logic [3:0] be,
                      input logic [31:0] wd, input bit c);
    bit busy, acc;
    busy      = (init_left > 0);
    exp_busy  = busy;
    req_valid = v;
    req_we    = we;
    req_addr  = 3'(a);
    req_be    = be;
    req_wdata = wd;
    clr       = c;
    acc = v && !busy && !c;
    if (c && !busy && prev_rd) void'(q1.pop_back());
    if (acc && we) begin
      for (int i = 0; i < 4; i++) if (be[i]) model_mem[a][i*8 +: 8] = wd[i*8 +: 8];
    end else if (acc) begin
      q0.push_back('{data: model_mem[a] & 32'h0000_00FF, due: cyc + 1});
      q1.push_back('{data: model_mem[a], due: cyc + 2});
    end
    prev_rd = acc && !we;
    @(posedge clk);
    if (init_left > 0) init_left--;
    else if (c) begin
      init_left = 8;
      zero_model();
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 4'h0, 32'd0, 1'b0);
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++)
      step(($urandom % 4) != 0, $urandom % 2, $urandom_range(0, 7), 4'($urandom),
           $urandom, ($urandom % 40) == 0);
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    clr       = 1'b0;
    q0.delete();
    q1.delete();
    zero_model();
    prev_rd  = 1'b0;
    exp_busy = 1'b1;
    last0    = 32'd0;
    last1    = 32'd0;
    #1;
    check("rst_rsp_valid0", {31'd0, rv0}, 32'd0);
    check("rst_rsp_valid1", {31'd0, rv1}, 32'd0);
    check("rst_rdata0", {24'd0, rd0}, 32'd0);
    check("rst_rdata1", rd1, 32'd0);
    repeat (n) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    init_left = 8;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 3'd0; req_be = 4'h0; req_wdata = 32'd0;
    do_reset(3);
    // Requests during the sweep must be refused.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, i, 4'h0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, i, 4'h0, 32'd0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 3, 4'hF, 32'h0000_00A5, 1'b0);
    step(1'b1, 1'b0, 3, 4'h0, 32'd0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 5, 4'hF, 32'h1122_3344, 1'b0);
    step(1'b1, 1'b1, 5, 4'h5, 32'hAABB_CCDD, 1'b0);
    step(1'b1, 1'b0, 5, 4'h0, 32'd0, 1'b0);
    idle(3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i, 4'hF, 32'h10 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i, 4'h0, 32'd0, 1'b0);
    idle(3);
    // Read then clr: the wide instance must squash its in-flight response.
    step(1'b1, 1'b0, 3, 4'h0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 2, 4'h0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i, 4'hF, 32'hFFFF_FFFF, i == 3);
    step(1'b1, 1'b0, 3, 4'h0, 32'd0, 1'b0);
    idle(3);
    rand_steps(400);
    // Reset in the middle of a read stream.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, i, 4'h0, 32'd0, 1'b0);
    do_reset(1);
    rand_steps(150);
    idle(5);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
